// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end for the single-cycle MIPS core: owns the PC, fetches over a req/rdy
// handshake, holds each word for execute and resolves jump/branch. Optional: FETCH_HALT_ON_ILLEGAL_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rdy,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst_out,
    output logic [5:0]         inst_opcode,
    output logic [31:0]        pc_out,
    input  logic               inst_ack,
    input  logic               jump,
    input  logic               branch,
    input  logic               alu_zero,
    output logic [COUNT_W-1:0] retired_cnt,
    output logic               halted
);

`ifdef FETCH_HALT_ON_ILLEGAL_EN
    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_ISSUE} state_t;
`endif

    state_t               state_reg, state_next;
    logic [31:0]          pc_reg, pc_next;
    logic [31:0]          inst_reg, inst_next;
    logic                 valid_reg, valid_next;
    logic [COUNT_W-1:0]   cnt_reg, cnt_next;

    logic [31:0]          pc4;
    logic [31:0]          branch_offset;
    logic [31:0]          jump_target;
    logic [31:0]          next_pc;

    assign pc4           = pc_reg + 32'd4;
    assign branch_offset = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
    assign jump_target   = {pc4[31:28], inst_reg[25:0], 2'b00};

    // Jump outranks branch; both only matter in the ack cycle.
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = pc4 + branch_offset;
        end
    end

`ifdef FETCH_HALT_ON_ILLEGAL_EN
    logic halted_reg, halted_next;
    logic opcode_legal;

    always_comb begin
        opcode_legal = 1'b0;
        case (inst_reg[31:26])
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: opcode_legal = 1'b1;
            default:                                               opcode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_reg <= 1'b0;
        end else begin
            halted_reg <= halted_next;
        end
    end

    assign halted = halted_reg;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            inst_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
        halted_next = halted_reg;
`endif
        case (state_reg)
            S_FETCH: begin
                if (imem_rdy) begin
                    inst_next  = imem_rdata;
                    valid_next = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (inst_ack) begin
                    valid_next = 1'b0;
`ifdef FETCH_HALT_ON_ILLEGAL_EN
                    // An illegal word is not retired; pc stays on it for post-mortem.
                    if (!opcode_legal) begin
                        state_next  = S_HALT;
                        halted_next = 1'b1;
                    end else begin
                        pc_next    = next_pc;
                        cnt_next   = cnt_reg + COUNT_W'(1);
                        state_next = S_FETCH;
                    end
`else
                    pc_next    = next_pc;
                    cnt_next   = cnt_reg + COUNT_W'(1);
                    state_next = S_FETCH;
`endif
                end
            end
`ifdef FETCH_HALT_ON_ILLEGAL_EN
            S_HALT: begin
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Request is masked during reset so memory never sees a fetch from a stale PC.
    assign imem_req    = (state_reg == S_FETCH) && !rst;
    assign imem_addr   = pc_reg;
    assign inst_valid  = valid_reg;
    assign inst_out    = inst_reg;
    assign inst_opcode = inst_reg[31:26];
    assign pc_out      = pc_reg;
    assign retired_cnt = cnt_reg;

endmodule
